// File: rtl/mlp_neuron.sv
// rtl/mlp_neuron.sv - serial fixed-point perceptron neuron: one MAC per clock, bias add, then ReLU or PLAN sigmoid activation.
module mlp_neuron #(
    parameter int bits            = 16,
    parameter int fractional_bits = 11,
    parameter int in_size         = 784,
    parameter int activation      = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic signed [bits-1:0] in      [0:in_size-1],
    input  logic signed [bits-1:0] weights [0:in_size-1],
    input  logic signed [bits-1:0] bias,
    output logic                   ready,
    output logic [bits-1:0]        out
);
    localparam int IDXW = (in_size > 1) ? $clog2(in_size) : 1;
    localparam int ACCW = 2 * bits + IDXW;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(in_size - 1);

    localparam logic signed [ACCW-1:0] XMAX = {{(ACCW-bits+1){1'b0}}, {(bits-1){1'b1}}};
    localparam logic signed [ACCW-1:0] XMIN = {{(ACCW-bits+1){1'b1}}, {(bits-1){1'b0}}};

    // PLAN breakpoints and offsets, scaled to the chosen fraction width.
    localparam logic [bits-1:0] C_ONE  = bits'(1 << fractional_bits);
    localparam logic [bits-1:0] C_FIVE = bits'(5 << fractional_bits);
    localparam logic [bits-1:0] C_2375 = bits'(19 << (fractional_bits - 3));
    localparam logic [bits-1:0] C_0844 = bits'(27 << (fractional_bits - 5));
    localparam logic [bits-1:0] C_0625 = bits'(5 << (fractional_bits - 3));
    localparam logic [bits-1:0] C_HALF = bits'(1 << (fractional_bits - 1));

    typedef enum logic [2:0] {IDLE, MAC, BIAS, ACT, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic [bits-1:0]         out_q, out_d;
    logic                    ready_q, ready_d;

    logic signed [2*bits-1:0] prod;
    logic signed [ACCW-1:0]   bias_sh;
    logic signed [ACCW-1:0]   x_wide;
    logic signed [bits-1:0]   x;
    logic [bits-1:0]          a;
    logic [bits-1:0]          y;
    logic [bits-1:0]          act;

    always_comb begin
        prod    = (2*bits)'(in[idx_q]) * (2*bits)'(weights[idx_q]);
        bias_sh = ACCW'(bias) <<< fractional_bits;
        x_wide  = acc_q >>> fractional_bits;
        if (x_wide > XMAX) begin
            x = XMAX[bits-1:0];
        end else if (x_wide < XMIN) begin
            x = XMIN[bits-1:0];
        end else begin
            x = x_wide[bits-1:0];
        end
    end

    always_comb begin
        // |x| saturates so the most negative code does not wrap back to itself.
        if (x[bits-1]) begin
            a = (x == XMIN[bits-1:0]) ? XMAX[bits-1:0] : -x;
        end else begin
            a = x;
        end
        if (a >= C_FIVE) begin
            y = C_ONE;
        end else if (a >= C_2375) begin
            y = (a >> 5) + C_0844;
        end else if (a >= C_ONE) begin
            y = (a >> 3) + C_0625;
        end else begin
            y = (a >> 2) + C_HALF;
        end
        if (activation != 0) begin
            act = x[bits-1] ? (C_ONE - y) : y;
        end else begin
            act = x[bits-1] ? '0 : x;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                    acc_d   = '0;
                    idx_d   = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + ACCW'(prod);
                if (idx_q == IDX_LAST) begin
                    state_d = BIAS;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            BIAS: begin
                acc_d   = acc_q + bias_sh;
                state_d = ACT;
            end
            ACT: begin
                out_d   = act;
                state_d = DONE;
            end
            DONE: begin
                // ready is shown for at least one cycle before a low start releases it.
                ready_d = 1'b1;
                if (ready_q && !start) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
endmodule

// File: tb/tb_mlp_neuron.sv
// tb/tb_mlp_neuron.sv - scoreboard bench for mlp_neuron, sigmoid and ReLU instances side by side.
module tb_mlp_neuron;
    localparam int N = 784;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start;
    logic signed [15:0] in_v [0:N-1];
    logic signed [15:0] w_v  [0:N-1];
    logic signed [15:0] bias_v;
    logic               ready_s, ready_r;
    logic [15:0]        out_s, out_r;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_s_q [$];
    logic [15:0] exp_r_q [$];

    mlp_neuron #(.bits(16), .fractional_bits(11), .in_size(N), .activation(1)) dut_sig (
        .clock(clk), .reset_n(rst_n), .start(start), .in(in_v), .weights(w_v),
        .bias(bias_v), .ready(ready_s), .out(out_s)
    );

    mlp_neuron #(.bits(16), .fractional_bits(11), .in_size(N), .activation(0)) dut_relu (
        .clock(clk), .reset_n(rst_n), .start(start), .in(in_v), .weights(w_v),
        .bias(bias_v), .ready(ready_r), .out(out_r)
    );

    function automatic logic [15:0] model(input bit sig);
        longint acc;
        longint x;
        longint a;
        longint y;
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(in_v[i]) * longint'(w_v[i]);
        acc += longint'(bias_v) * 2048;
        x = acc >>> 11;
        if (x > 32767) x = 32767;
        if (x < -32768) x = -32768;
        if (!sig) return (x < 0) ? 16'h0000 : 16'(x);
        a = (x < 0) ? ((x == -32768) ? 32767 : -x) : x;
        if (a >= 10240)     y = 2048;
        else if (a >= 4864) y = (a >>> 5) + 1728;
        else if (a >= 2048) y = (a >>> 3) + 1280;
        else                y = (a >>> 2) + 1024;
        return (x >= 0) ? 16'(y) : 16'(2048 - y);
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < N; i++) begin
            in_v[i] = '0;
            w_v[i]  = '0;
        end
        bias_v = '0;
    endtask

    task automatic run_vector(input string name, input logic [15:0] es, input logic [15:0] er, input int hold);
        int lat;
        logic [15:0] ps, pr;
        exp_s_q.push_back(es);
        exp_r_q.push_back(er);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready_s && lat < 1000);
        ps = exp_s_q.pop_front();
        pr = exp_r_q.pop_front();
        n_tests++;
        if (ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: ready=%b after %0d cycles, required 1", name, ready_s, lat);
            start = 1'b0;
            return;
        end
        n_tests++;
        if (lat !== N + 3) begin
            n_fail++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, N + 3);
        end
        n_tests++;
        if (out_s !== ps) begin
            n_fail++;
            $display("FAIL %s sigmoid: got %h, required %h", name, out_s, ps);
        end
        n_tests++;
        if (ready_r !== 1'b1 || out_r !== pr) begin
            n_fail++;
            $display("FAIL %s relu: ready=%b out=%h, required ready=1 out=%h", name, ready_r, out_r, pr);
        end
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (ready_s !== 1'b1 || out_s !== ps) begin
                n_fail++;
                $display("FAIL %s hold: ready=%b out=%h, required ready=1 out=%h", name, ready_s, out_s, ps);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (ready_s !== 1'b0 || out_s !== ps) begin
            n_fail++;
            $display("FAIL %s drop: ready=%b out=%h, required ready=0 out=%h", name, ready_s, out_s, ps);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        clear_vec();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ready_s !== 1'b0 || out_s !== 16'h0000 || ready_r !== 1'b0 || out_r !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset: ready=%b/%b out=%h/%h, required 0/0 0000/0000", ready_s, ready_r, out_s, out_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_input();
        clear_vec();
        for (int i = 0; i < N; i++) w_v[i] = 16'($urandom);
        run_vector("zero_in", 16'h0400, 16'h0000, 0);
    endtask

    task automatic test_unit_products();
        clear_vec();
        in_v[0] = 16'h0800;
        w_v[0]  = 16'h0800;
        run_vector("one_x_one", 16'h0600, 16'h0800, 0);
        bias_v = 16'hF800;
        run_vector("bias_cancel", 16'h0400, 16'h0000, 0);
        clear_vec();
        in_v[0] = 16'h0800;
        w_v[0]  = 16'hF800;
        run_vector("neg_one", 16'h0200, 16'h0000, 0);
        clear_vec();
        in_v[N-1] = 16'h1000;
        w_v[N-1]  = 16'h0800;
        run_vector("last_index", 16'h0700, 16'h1000, 0);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < N; i++) begin
            in_v[i] = 16'h7FFF;
            w_v[i]  = 16'h7FFF;
        end
        bias_v = '0;
        run_vector("saturate", 16'h0800, 16'h7FFF, 0);
    endtask

    task automatic test_random();
        int amps [3] = '{64, 512, 4096};
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                in_v[i] = 16'(int'($urandom_range(0, 2 * amps[r] - 1)) - amps[r]);
                w_v[i]  = 16'(int'($urandom_range(0, 2 * amps[r] - 1)) - amps[r]);
            end
            bias_v = 16'(int'($urandom_range(0, 8191)) - 4096);
            run_vector($sformatf("random%0d", r), model(1'b1), model(1'b0), 0);
        end
    endtask

    task automatic test_back_to_back();
        clear_vec();
        in_v[5] = 16'h1800;
        w_v[5]  = 16'h0C00;
        run_vector("hold_start", model(1'b1), model(1'b0), 20);
        run_vector("restart", model(1'b1), model(1'b0), 0);
    endtask

    task automatic test_reset_mid();
        clear_vec();
        in_v[0] = 16'h0800;
        w_v[0]  = 16'h0800;
        @(negedge clk);
        start = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ready_s !== 1'b0 || out_s !== 16'h0000 || out_r !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b out=%h/%h, required ready=0 out=0000/0000", ready_s, out_s, out_r);
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        run_vector("after_reset", 16'h0600, 16'h0800, 0);
    endtask

    initial begin
        test_reset();
        test_zero_input();
        test_unit_products();
        test_random();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
